// File: rtl/ahb_ram_slave.sv
// ---------------------------------------------------------------------------
// ahb_ram_slave
//
// AHB-Lite single-port SRAM slave. It accepts NONSEQ/SEQ transfers and
// performs byte, halfword and word reads and writes on an internal
// register-array memory of 2^ADDR_WIDTH 32-bit words. Every legal data phase
// can be stretched by WAIT_STATES hreadyout-low cycles. Illegal transfers
// (oversized, misaligned or out of range) get a two-cycle ERROR response and
// never touch memory.
//
// Parameters
//   ADDR_WIDTH   word-address bits (memory depth 2^ADDR_WIDTH words)
//   WAIT_STATES  hreadyout-low cycles in every OKAY data phase (0..15)
//
// Ports
//   hclk       in   bus clock, rising edge
//   hresetn    in   asynchronous active-low reset
//   hsel       in   slave select (address phase)
//   haddr      in   byte address (address phase)
//   htrans     in   IDLE/BUSY/NONSEQ/SEQ
//   hwrite     in   1 = write, 0 = read
//   hsize      in   0 = byte, 1 = halfword, 2 = word
//   hburst     in   burst type, ignored
//   hwdata     in   write data (data phase)
//   hready     in   global bus ready
//   hreadyout  out  slave ready (data phase)
//   hresp      out  0 = OKAY, 1 = ERROR
//   hrdata     out  read data (data phase)
// ---------------------------------------------------------------------------
module ahb_ram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic                  write_q;
  logic [2:0]            size_q;

  logic                  can_accept;
  logic                  accept;
  logic                  illegal;
  logic [3:0]            lane_en;
  logic                  commit;

  logic [31:0]           mem [DEPTH];

  // hburst and htrans[0] carry no meaning for this slave.
  logic unused_bits;
  assign unused_bits = ^{hburst, htrans[0]};

  // A new address phase can only close in a cycle where this slave drives
  // hreadyout high; WAIT and ERR1 never sample the bus.
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept     = hsel & hready & htrans[1] & can_accept;

  // Legality of the transfer currently in its address phase.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    illegal = 1'b0;
    if (hsize > 3'd2)                             illegal = 1'b1;
    if ((hsize == 3'd1) && haddr[0])              illegal = 1'b1;
    if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) illegal = 1'b1;
    if ((haddr >> (ADDR_WIDTH + 2)) != 32'd0)     illegal = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (!accept) begin
          state_d = ST_IDLE;
        end else if (illegal) begin
          state_d = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_LOAD;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = ST_DATA;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs. Reads come straight from the array through addr_q,
  // so a read following a write in the pipeline sees the committed data.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = 32'h0;
    case (state_q)
      ST_WAIT: hreadyout = 1'b0;
      ST_DATA: if (!write_q) hrdata = mem[addr_q[ADDR_WIDTH+1:2]];
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (!hresetn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept) begin
        addr_q  <= haddr[ADDR_WIDTH+1:0];
        write_q <= hwrite;
        size_q  <= hsize;
      end
    end
  end

  // Little-endian byte lanes of the transfer in its data phase. Only legal
  // sizes ever reach DATA, so the default is unreachable in practice.
  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      3'd0:    lane_en = 4'b0001 << addr_q[1:0];
      3'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  // A write commits at the edge that closes its DATA cycle. Reset forces
  // IDLE asynchronously, so a write still waiting in WAIT is dropped.
  assign commit = (state_q == ST_DATA) && write_q;

  // NOTE: the memory array has no reset; clearing it would turn the RAM into
  // thousands of resettable flops and its contents are undefined until written.
  always_ff @(posedge hclk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[addr_q[ADDR_WIDTH+1:2]][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_ram_slave
//
// Three slave instances (WAIT_STATES 0, 2, 3), each running as the only
// slave on its own bus with hready tied to its own hreadyout. Each address
// phase pushes the expected response (wait cycles, hresp, hrdata) computed
// from a reference memory model into a scoreboard; a negedge monitor pops
// and compares when the data phase completes.
// ---------------------------------------------------------------------------
module tb_ahb_ram_slave;

  localparam int AW = 10;
  localparam int NI = 3;
  localparam int WS [NI] = '{0, 2, 3};

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic [NI-1:0] hsel;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [31:0]   hwdata;
  wire  [NI-1:0] ro;
  wire  [NI-1:0] rs;
  wire  [31:0]   rd [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ahb_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS[g])) u_dut (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .hsel      (hsel[g]),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hburst    (hburst),
      .hwdata    (hwdata),
      .hready    (ro[g]),
      .hreadyout (ro[g]),
      .hresp     (rs[g]),
      .hrdata    (rd[g])
    );
  end

  always #5 hclk = ~hclk;

  typedef struct {
    int          inst;
    int          waits;
    logic        resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [31:0] model [int];
  int          checks   = 0;
  int          errors   = 0;
  int          wait_cnt = 0;

  function automatic int key(input int inst, input logic [31:0] a);
    return (inst << 16) | int'(a[AW+1:2]);
  endfunction

  function automatic bit legal(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b0;
    if (s == 3'd1 && a[0]) return 1'b0;
    if (s == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    return a < (32'd4 << AW);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [31:0] a, input logic [2:0] s);
    logic [31:0] r;
    r = old;
    case (s)
      3'd0:    r[8*a[1:0] +: 8] = wd[8*a[1:0] +: 8];
      3'd1:    r[16*a[1] +: 16] = wd[16*a[1] +: 16];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Present one address phase, wait for it to be accepted, then drive its
  // write data and push the expected data-phase response. Called and
  // returning just after a rising edge.
  task automatic addr_phase(input int inst, input logic [1:0] tr, input logic [31:0] a,
                            input logic wr, input logic [2:0] s, input logic [31:0] wd);
    exp_t e;
    int   n;
    int   k;
    hsel         = '0;
    hsel[inst]   = 1'b1;
    htrans       = tr;
    haddr        = a;
    hwrite       = wr;
    hsize        = s;
    hburst       = 3'b001;
    n = 0;
    @(negedge hclk);
    while (ro[inst] !== 1'b1 && n < 40) begin
      n++;
      @(negedge hclk);
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL addr_accept_timeout inst %0d hreadyout=%b required 1", inst, ro[inst]);
    end
    @(posedge hclk);
    #1;
    hwdata  = wd;
    e.inst  = inst;
    e.waits = WS[inst];
    e.resp  = 1'b0;
    e.rdata = 32'h0;
    if (!tr[1]) begin
      e.waits = 0;
    end else if (!legal(a, s)) begin
      e.waits = 1;
      e.resp  = 1'b1;
    end else begin
      k = key(inst, a);
      if (wr) model[k] = merge(model.exists(k) ? model[k] : 32'h0, wd, a, s);
      else    e.rdata  = model.exists(k) ? model[k] : 32'h0;
    end
    sb.push_back(e);
    hsel   = '0;
    htrans = T_IDLE;
    hwrite = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      n++;
      @(negedge hclk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
      sb.delete();
    end
    @(posedge hclk);
    #1;
  endtask

  // Data-phase monitor: hresp checked every cycle of the data phase; wait
  // count and hrdata checked in the completing cycle.
  always @(negedge hclk) begin
    if (hresetn === 1'b1 && sb.size() > 0) begin
      mon_e = sb[0];
      checks++;
      if (rs[mon_e.inst] !== mon_e.resp) begin
        errors++;
        $display("FAIL hresp inst %0d got %b required %b", mon_e.inst, rs[mon_e.inst], mon_e.resp);
      end
      if (ro[mon_e.inst] === 1'b1) begin
        checks++;
        if (wait_cnt != mon_e.waits) begin
          errors++;
          $display("FAIL wait_cycles inst %0d got %0d required %0d", mon_e.inst, wait_cnt, mon_e.waits);
        end
        checks++;
        if (rd[mon_e.inst] !== mon_e.rdata) begin
          errors++;
          $display("FAIL hrdata inst %0d got %h required %h", mon_e.inst, rd[mon_e.inst], mon_e.rdata);
        end
        void'(sb.pop_front());
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic check_idle_outputs(input int inst, input string tag);
    checks++;
    if (ro[inst] !== 1'b1 || rs[inst] !== 1'b0 || rd[inst] !== 32'h0) begin
      errors++;
      $display("FAIL %s inst %0d got ready=%b resp=%b rdata=%h required 1 0 00000000",
               tag, inst, ro[inst], rs[inst], rd[inst]);
    end
  endtask

  task automatic test_reset();
    hresetn = 1'b1;
    hsel    = '0;
    haddr   = 32'h0;
    htrans  = T_IDLE;
    hwrite  = 1'b0;
    hsize   = 3'd0;
    hburst  = 3'd0;
    hwdata  = 32'h0;
    #2 hresetn = 1'b0;
    #2;
    for (int i = 0; i < NI; i++) check_idle_outputs(i, "reset_outputs");
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
  endtask

  task automatic test_back_to_back();
    addr_phase(0, T_NONSEQ, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    addr_phase(0, T_NONSEQ, 32'h10, 1'b0, 3'd2, 32'h0);
    drain();
  endtask

  task automatic test_lanes();
    logic [31:0] a;
    logic [2:0]  s;
    addr_phase(0, T_NONSEQ, 32'h10, 1'b1, 3'd2, 32'h00000000);
    addr_phase(0, T_NONSEQ, 32'h11, 1'b1, 3'd0, 32'h0000AA00);
    addr_phase(0, T_SEQ,    32'h12, 1'b1, 3'd1, 32'h12340000);
    addr_phase(0, T_NONSEQ, 32'h10, 1'b0, 3'd2, 32'h0);
    for (int i = 0; i < 8; i++) addr_phase(0, T_NONSEQ, 32'h40 + 32'(4 * i), 1'b1, 3'd2, $urandom);
    for (int i = 0; i < 16; i++) begin
      s = 3'($urandom_range(0, 2));
      a = 32'h40 + 32'($urandom_range(0, 31));
      if (s == 3'd1) a[0] = 1'b0;
      if (s == 3'd2) a[1:0] = 2'b00;
      addr_phase(0, T_NONSEQ, a, 1'b1, s, $urandom);
      addr_phase(0, T_NONSEQ, {a[31:2], 2'b00}, 1'b0, 3'd2, 32'h0);
    end
    drain();
  endtask

  task automatic test_wait_states();
    addr_phase(1, T_NONSEQ, 32'h20, 1'b1, 3'd2, 32'hA5A50F0F);
    addr_phase(1, T_NONSEQ, 32'h20, 1'b0, 3'd2, 32'h0);
    addr_phase(1, T_NONSEQ, 32'h22, 1'b1, 3'd1, 32'hBEEF0000);
    addr_phase(1, T_NONSEQ, 32'h20, 1'b0, 3'd2, 32'h0);
    addr_phase(1, T_NONSEQ, 32'h21, 1'b1, 3'd2, 32'hFFFFFFFF);
    addr_phase(1, T_NONSEQ, 32'h20, 1'b0, 3'd2, 32'h0);
    drain();
  endtask

  task automatic test_errors();
    addr_phase(0, T_NONSEQ, 32'h00, 1'b1, 3'd2, 32'h11223344);
    addr_phase(0, T_NONSEQ, 32'h02, 1'b1, 3'd2, 32'hFFFFFFFF);
    addr_phase(0, T_NONSEQ, 32'h00, 1'b0, 3'd2, 32'h0);
    addr_phase(0, T_NONSEQ, 32'h00, 1'b1, 3'd3, 32'hFFFFFFFF);
    addr_phase(0, T_NONSEQ, 32'h1000, 1'b1, 3'd2, 32'hFFFFFFFF);
    addr_phase(0, T_NONSEQ, 32'h1000, 1'b0, 3'd2, 32'h0);
    addr_phase(0, T_NONSEQ, 32'h01, 1'b1, 3'd1, 32'hFFFFFFFF);
    addr_phase(0, T_NONSEQ, 32'h80000000, 1'b1, 3'd0, 32'hFFFFFFFF);
    addr_phase(0, T_NONSEQ, 32'h00, 1'b0, 3'd2, 32'h0);
    addr_phase(0, T_NONSEQ, 32'hFFC, 1'b1, 3'd2, 32'h0BADF00D);
    addr_phase(0, T_NONSEQ, 32'hFFF, 1'b1, 3'd0, 32'h77000000);
    addr_phase(0, T_NONSEQ, 32'hFFC, 1'b0, 3'd2, 32'h0);
    drain();
  endtask

  task automatic test_idle_busy();
    addr_phase(0, T_IDLE, 32'h00, 1'b1, 3'd2, 32'hFFFFFFFF);
    addr_phase(0, T_BUSY, 32'h00, 1'b1, 3'd2, 32'hFFFFFFFF);
    addr_phase(0, T_NONSEQ, 32'h00, 1'b0, 3'd2, 32'h0);
    drain();
  endtask

  task automatic test_reset_mid_wait();
    int          k;
    logic [31:0] old;
    addr_phase(2, T_NONSEQ, 32'h30, 1'b1, 3'd2, 32'hCAFEF00D);
    drain();
    k   = key(2, 32'h30);
    old = model[k];
    addr_phase(2, T_NONSEQ, 32'h30, 1'b1, 3'd2, 32'h55555555);
    @(posedge hclk);
    #1;
    checks++;
    if (ro[2] !== 1'b0) begin
      errors++;
      $display("FAIL second_wait_cycle hreadyout=%b required 0", ro[2]);
    end
    hresetn = 1'b0;
    sb.delete();
    wait_cnt = 0;
    model[k] = old;
    #1;
    check_idle_outputs(2, "reset_mid_wait");
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    addr_phase(2, T_NONSEQ, 32'h30, 1'b0, 3'd2, 32'h0);
    drain();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_lanes();
    test_wait_states();
    test_errors();
    test_idle_busy();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
